// File: rtl/gcd_engine.sv
// Single-block GCD engine with operand/result valid-ready handshakes.
// STEIN selects repeated subtraction (0) or binary Stein reduction (1) at elaboration.
module gcd_engine #(
    parameter int N     = 8,
    parameter int STEIN = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] p_in,
    input  logic [N-1:0] q_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r_out,
    output logic         zero_in,
    output logic [N-1:0] cycles
);

    localparam int KW = $clog2(N) + 1;
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [N-1:0]  CNT_ONE = N'(1);
    localparam logic [N-1:0]  CNT_MAX = {N{1'b1}};

    // state  | meaning
    // S_IDLE | waiting for an operand pair, in_ready high
    // S_CALC | one reduction rule per cycle until a terminal rule fires
    // S_DONE | result presented, held until out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [N-1:0]  r_p, r_q, r_cnt, r_res, r_cycles;
    logic [KW-1:0] r_k;
    logic          r_zero;

    logic [N-1:0]  w_p_nxt, w_q_nxt, w_cnt_nxt, w_res_nxt, w_cycles_nxt;
    logic [KW-1:0] w_k_nxt;
    logic          w_zero_nxt;

    logic          w_term;
    logic [N-1:0]  w_term_base;
    logic [N-1:0]  w_term_val;
    logic [N-1:0]  w_cnt_inc;
    logic [N-1:0]  w_diff;
    logic          w_p_gt_q;

    assign w_p_gt_q    = (r_p > r_q);
    assign w_diff      = w_p_gt_q ? (r_p - r_q) : (r_q - r_p);
    assign w_term      = (r_p == '0) || (r_q == '0) || (r_p == r_q);
    assign w_term_base = (r_p == '0) ? r_q : r_p;
    assign w_term_val  = (STEIN != 0) ? (w_term_base << r_k) : w_term_base;
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    always_comb begin
        w_state_nxt  = r_state;
        w_p_nxt      = r_p;
        w_q_nxt      = r_q;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        w_res_nxt    = r_res;
        w_cycles_nxt = r_cycles;
        w_zero_nxt   = r_zero;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_p_nxt     = p_in;
                    w_q_nxt     = q_in;
                    w_k_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_zero_nxt  = (p_in == '0) || (q_in == '0);
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_term) begin
                    w_res_nxt    = w_term_val;
                    w_cycles_nxt = w_cnt_inc;
                    w_state_nxt  = S_DONE;
                end else if (STEIN == 0) begin
                    if (w_p_gt_q) w_p_nxt = w_diff;
                    else          w_q_nxt = w_diff;
                end else begin
                    // Common factors of two are stripped into k and restored at termination
                    if (!r_p[0] && !r_q[0]) begin
                        w_p_nxt = r_p >> 1;
                        w_q_nxt = r_q >> 1;
                        w_k_nxt = r_k + K_ONE;
                    end else if (!r_p[0]) begin
                        w_p_nxt = r_p >> 1;
                    end else if (!r_q[0]) begin
                        w_q_nxt = r_q >> 1;
                    end else if (w_p_gt_q) begin
                        w_p_nxt = w_diff >> 1;
                    end else begin
                        w_q_nxt = w_diff >> 1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_q      <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_cycles <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_p      <= w_p_nxt;
            r_q      <= w_q_nxt;
            r_k      <= w_k_nxt;
            r_cnt    <= w_cnt_nxt;
            r_res    <= w_res_nxt;
            r_cycles <= w_cycles_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign r_out     = r_res;
    assign zero_in   = r_zero;
    assign cycles    = r_cycles;

endmodule
